// File: rtl/stage3_exec_md_if.sv
// Execute-stage bus: operands and control from register-read, results,
// redirect and hold signals back out.
interface stage3_exec_md_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            stall_in;
    logic            flush_in;
    logic [3:0]      op;
    logic            use_imm;
    logic [1:0]      bypass;
    logic [XLEN-1:0] rs1_read;
    logic [XLEN-1:0] rs2_read;
    logic [XLEN-1:0] rs1_bypass_value;
    logic [XLEN-1:0] rs2_bypass_value;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] eval;
    logic            eval_valid;
    logic [XLEN-1:0] s4a_rs2_val;
    logic            busy;
    logic            do_flush;
    logic [XLEN-1:0] redirect_addr;

    modport master (
        output valid, stall_in, flush_in, op, use_imm, bypass,
               rs1_read, rs2_read, rs1_bypass_value, rs2_bypass_value, imm, pc,
        input  eval, eval_valid, s4a_rs2_val, busy, do_flush, redirect_addr
    );

    modport slave (
        input  valid, stall_in, flush_in, op, use_imm, bypass,
               rs1_read, rs2_read, rs1_bypass_value, rs2_bypass_value, imm, pc,
        output eval, eval_valid, s4a_rs2_val, busy, do_flush, redirect_addr
    );
endinterface

// File: rtl/stage3_exec_md.sv
// Execute stage: operand bypass, ALU / jump / branch resolution, redirect,
// and an iterative radix-2 multiply / restoring-divide unit.
module stage3_exec_md #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input logic              clock,
    input logic              reset,
    stage3_exec_md_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [XLEN-1:0] md_select(input logic take_hi,
                                                  input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo);
        return take_hi ? hi : lo;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         md_op;
    logic [XLEN-1:0]    acc_hi;
    logic [XLEN-1:0]    acc_lo;
    logic [XLEN-1:0]    opb;

    logic [XLEN-1:0]    eval_p1;
    logic               vld_p1;
    logic [XLEN-1:0]    rs2_p1;

    logic [XLEN-1:0]        rs1v, rs2v, arg2;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]        jalr_sum, sc_result;
    logic                   is_md, is_branch, is_jal, is_jalr, taken, ctrl;
    logic                   md_start_req, md_start, sc_fire, done_fire, sc_writes;

    logic [XLEN:0]          mul_sum, div_shift, div_diff;
    logic                   div_ok;
    logic [XLEN-1:0]        mul_hi_next, mul_lo_next, div_hi_next, div_lo_next;

    // ---- stage p0: operand select, decode, control transfer ----
    assign rs1v  = bus.bypass[0] ? bus.rs1_bypass_value : bus.rs1_read;
    assign rs2v  = bus.bypass[1] ? bus.rs2_bypass_value : bus.rs2_read;
    assign arg2  = bus.use_imm ? bus.imm : rs2v;
    assign rs1_s = rs1v;
    assign rs2_s = rs2v;

    assign is_md     = (bus.op[3:2] == 2'b10);
    assign is_branch = (bus.op[3:2] == 2'b01);
    assign is_jal    = (bus.op == 4'd2);
    assign is_jalr   = (bus.op == 4'd3);
    assign sc_writes = (bus.op[3:2] == 2'b00) | (bus.op[3:2] == 2'b11);

    // Branch condition decoded from the low op bits.
    always_comb begin
        taken = 1'b0;
        case (bus.op[1:0])
            2'd0:    taken = (rs1v == rs2v);
            2'd1:    taken = (rs1v != rs2v);
            2'd2:    taken = (rs1_s < rs2_s);
            default: taken = (rs1_s >= rs2_s);
        endcase
    end

    assign ctrl              = is_jal | is_jalr | (is_branch & taken);
    assign bus.do_flush      = bus.valid & ~bus.stall_in & ~bus.flush_in & ctrl;
    assign jalr_sum          = rs1v + bus.imm;
    assign bus.redirect_addr = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.pc + bus.imm;

    // Single-cycle result; ops 12-15 fall into the ADD arm.
    always_comb begin
        sc_result = rs1v + arg2;
        case (bus.op)
            4'd1:       sc_result = rs1v - arg2;
            4'd2, 4'd3: sc_result = bus.pc + XLEN'(4);
            default:    sc_result = rs1v + arg2;
        endcase
    end

    assign md_start_req = (state == S_IDLE) & bus.valid & is_md & (MUL_EN != 0);
    assign md_start     = md_start_req & ~bus.stall_in & ~bus.flush_in;
    assign bus.busy     = md_start_req | (state == S_RUN);
    assign sc_fire      = (state == S_IDLE) & bus.valid & ~bus.stall_in & ~bus.flush_in & ~bus.busy;
    assign done_fire    = (state == S_DONE) & ~bus.stall_in & ~bus.flush_in;

    // One shift-add step: conditionally add multiplicand to the high half, shift right.
    assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign mul_hi_next = mul_sum[XLEN:1];
    assign mul_lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign div_shift   = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff    = div_shift - {1'b0, opb};
    assign div_ok      = (div_shift >= {1'b0, opb});
    assign div_hi_next = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_lo_next = {acc_lo[XLEN-2:0], div_ok};

    // Multiply/divide sequencer: IDLE -> RUN (XLEN iterations) -> DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (md_start) begin
                    state <= S_RUN;
                    cnt   <= CNT_W'(XLEN - 1);
                end
                S_RUN: begin
                    if (bus.flush_in)    state <= S_IDLE;
                    else if (cnt == '0)  state <= S_DONE;
                    else                 cnt   <= cnt - 1'b1;
                end
                S_DONE: if (bus.flush_in || !bus.stall_in) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Iteration datapath: operands latched at start, one step per RUN cycle.
    always_ff @(posedge clock) begin
        if (md_start) begin
            md_op  <= bus.op[1:0];
            acc_hi <= '0;
            acc_lo <= rs1v;
            opb    <= rs2v;
        end else if (state == S_RUN) begin
            acc_hi <= md_op[1] ? div_hi_next : mul_hi_next;
            acc_lo <= md_op[1] ? div_lo_next : mul_lo_next;
        end
    end

    // ---- stage p1: result registers, frozen by downstream stall ----
    always_ff @(posedge clock) begin
        if (!reset) begin
            eval_p1 <= '0;
            vld_p1  <= 1'b0;
            rs2_p1  <= '0;
        end else if (!bus.stall_in) begin
            vld_p1 <= done_fire | (sc_fire & sc_writes);
            if (done_fire) begin
                eval_p1 <= md_select(md_op[0], acc_hi, acc_lo);
                rs2_p1  <= rs2v;
            end else if (sc_fire) begin
                eval_p1 <= sc_result;
                rs2_p1  <= rs2v;
            end
        end
    end

    assign bus.eval        = eval_p1;
    assign bus.eval_valid  = vld_p1;
    assign bus.s4a_rs2_val = rs2_p1;
endmodule

// File: tb/tb_stage3_exec_md.sv
// Directed bench for stage3_exec_md at XLEN=32.
module tb_stage3_exec_md;
    localparam int XLEN = 32;

    logic clock;
    logic reset;
    int   passed;
    int   total;

    stage3_exec_md_if #(.XLEN(XLEN)) bus ();

    stage3_exec_md #(.XLEN(XLEN), .MUL_EN(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.valid = 0; bus.stall_in = 0; bus.flush_in = 0; bus.op = 4'd0;
        bus.use_imm = 0; bus.bypass = 2'b00;
        bus.rs1_read = '0; bus.rs2_read = '0;
        bus.rs1_bypass_value = '0; bus.rs2_bypass_value = '0;
        bus.imm = '0; bus.pc = '0;
    endtask

    task automatic present(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        clear_inputs();
        bus.valid = 1; bus.op = op; bus.rs1_read = a; bus.rs2_read = b;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        tick(); tick();
        reset = 1;
        #1;
        total++; if (bus.eval !== 32'h0) $display("FAIL reset_eval: got %h expected %h", bus.eval, 32'h0); else passed++;
        total++; if (bus.eval_valid !== 1'b0) $display("FAIL reset_eval_valid: got %b expected 0", bus.eval_valid); else passed++;
        total++; if (bus.s4a_rs2_val !== 32'h0) $display("FAIL reset_s4a: got %h expected %h", bus.s4a_rs2_val, 32'h0); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.do_flush !== 1'b0) $display("FAIL reset_do_flush: got %b expected 0", bus.do_flush); else passed++;
        tick();
    endtask

    task automatic test_alu();
        present(4'd0, 32'd5, 32'd99);
        bus.rs2_bypass_value = 32'd7; bus.bypass = 2'b10;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL add_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.do_flush !== 1'b0) $display("FAIL add_do_flush: got %b expected 0", bus.do_flush); else passed++;
        tick();
        total++; if (bus.eval !== 32'd12) $display("FAIL add_eval: got %h expected %h", bus.eval, 32'd12); else passed++;
        total++; if (bus.eval_valid !== 1'b1) $display("FAIL add_eval_valid: got %b expected 1", bus.eval_valid); else passed++;
        total++; if (bus.s4a_rs2_val !== 32'd7) $display("FAIL add_s4a: got %h expected %h", bus.s4a_rs2_val, 32'd7); else passed++;
        // SUB with immediate and rs1 bypass: 5 - 8
        present(4'd1, 32'd77, 32'd3);
        bus.rs1_bypass_value = 32'd5; bus.bypass = 2'b01; bus.use_imm = 1; bus.imm = 32'd8;
        tick();
        total++; if (bus.eval !== 32'hFFFF_FFFD) $display("FAIL sub_eval: got %h expected %h", bus.eval, 32'hFFFF_FFFD); else passed++;
        total++; if (bus.s4a_rs2_val !== 32'd3) $display("FAIL sub_s4a: got %h expected %h", bus.s4a_rs2_val, 32'd3); else passed++;
        clear_inputs();
        tick();
        total++; if (bus.eval_valid !== 1'b0) $display("FAIL bubble_eval_valid: got %b expected 0", bus.eval_valid); else passed++;
    endtask

    task automatic test_control();
        present(4'd3, 32'h203, 32'h0);
        bus.pc = 32'h300; bus.imm = 32'h0;
        #1;
        total++; if (bus.do_flush !== 1'b1) $display("FAIL jalr_do_flush: got %b expected 1", bus.do_flush); else passed++;
        total++; if (bus.redirect_addr !== 32'h202) $display("FAIL jalr_target: got %h expected %h", bus.redirect_addr, 32'h202); else passed++;
        tick();
        total++; if (bus.eval !== 32'h304) $display("FAIL jalr_eval: got %h expected %h", bus.eval, 32'h304); else passed++;
        total++; if (bus.eval_valid !== 1'b1) $display("FAIL jalr_eval_valid: got %b expected 1", bus.eval_valid); else passed++;
        present(4'd6, 32'hFFFF_FFFF, 32'd1);
        bus.pc = 32'h100; bus.imm = 32'h20;
        #1;
        total++; if (bus.do_flush !== 1'b1) $display("FAIL blt_do_flush: got %b expected 1", bus.do_flush); else passed++;
        total++; if (bus.redirect_addr !== 32'h120) $display("FAIL blt_target: got %h expected %h", bus.redirect_addr, 32'h120); else passed++;
        tick();
        total++; if (bus.eval_valid !== 1'b0) $display("FAIL blt_eval_valid: got %b expected 0", bus.eval_valid); else passed++;
        present(4'd7, 32'hFFFF_FFFF, 32'd1);
        #1;
        total++; if (bus.do_flush !== 1'b0) $display("FAIL bge_not_taken: got %b expected 0", bus.do_flush); else passed++;
        present(4'd4, 32'd9, 32'd9);
        bus.stall_in = 1;
        #1;
        total++; if (bus.do_flush !== 1'b0) $display("FAIL beq_stalled: got %b expected 0", bus.do_flush); else passed++;
        bus.stall_in = 0;
        #1;
        total++; if (bus.do_flush !== 1'b1) $display("FAIL beq_taken: got %b expected 1", bus.do_flush); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic run_md(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] expv, input string name);
        int n;
        present(op, a, b);
        #1;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(posedge clock);
            #2;
        end
        total++; if (n !== 33) $display("FAIL %s_busy_cycles: got %0d expected 33", name, n); else passed++;
        total++; if (bus.eval_valid !== 1'b0) $display("FAIL %s_valid_while_busy: got %b expected 0", name, bus.eval_valid); else passed++;
        tick();
        total++; if (bus.eval !== expv) $display("FAIL %s_eval: got %h expected %h", name, bus.eval, expv); else passed++;
        total++; if (bus.eval_valid !== 1'b1) $display("FAIL %s_eval_valid: got %b expected 1", name, bus.eval_valid); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_muldiv();
        run_md(4'd8,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul");
        run_md(4'd9,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "mulhu");
        run_md(4'd10, 32'd100, 32'd0, 32'hFFFF_FFFF, "divu_zero");
        run_md(4'd11, 32'd100, 32'd0, 32'd100, "remu_zero");
        run_md(4'd10, 32'd100, 32'd7, 32'd14, "divu");
        run_md(4'd11, 32'd100, 32'd7, 32'd2, "remu");
    endtask

    task automatic test_flush();
        int seen;
        present(4'd10, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        bus.flush_in = 1; bus.valid = 0;
        #1;
        total++; if (bus.busy !== 1'b1) $display("FAIL flush_busy_in_run: got %b expected 1", bus.busy); else passed++;
        tick();
        bus.flush_in = 0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", bus.busy); else passed++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.eval_valid || bus.busy) seen++;
        end
        total++; if (seen !== 0) $display("FAIL flush_no_result: got %0d active cycles expected 0", seen); else passed++;
    endtask

    task automatic test_back_to_back_stall();
        int n;
        present(4'd0, 32'd10, 32'd2);
        tick();
        total++; if (bus.eval !== 32'd12) $display("FAIL b2b_add_eval: got %h expected %h", bus.eval, 32'd12); else passed++;
        present(4'd8, 32'd3, 32'd5);
        #1;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(posedge clock);
            #2;
        end
        total++; if (n !== 33) $display("FAIL b2b_mul_busy_cycles: got %0d expected 33", n); else passed++;
        bus.stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.eval !== 32'd12) $display("FAIL stall_hold_eval: got %h expected %h", bus.eval, 32'd12); else passed++;
            total++; if (bus.eval_valid !== 1'b0) $display("FAIL stall_hold_valid: got %b expected 0", bus.eval_valid); else passed++;
        end
        bus.stall_in = 0;
        tick();
        total++; if (bus.eval !== 32'd15) $display("FAIL stall_release_eval: got %h expected %h", bus.eval, 32'd15); else passed++;
        total++; if (bus.eval_valid !== 1'b1) $display("FAIL stall_release_valid: got %b expected 1", bus.eval_valid); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int active;
        present(4'd8, 32'd7, 32'd9);
        for (int i = 0; i < 5; i++) tick();
        reset = 0; bus.valid = 0;
        tick();
        reset = 1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.eval !== 32'h0) $display("FAIL midrun_reset_eval: got %h expected %h", bus.eval, 32'h0); else passed++;
        active = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.busy || bus.eval_valid) active++;
        end
        total++; if (active !== 0) $display("FAIL midrun_reset_idle: got %0d active cycles expected 0", active); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 0;
        clear_inputs();
        test_reset();
        test_alu();
        test_control();
        test_muldiv();
        test_flush();
        test_back_to_back_stall();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stage3_exec_md.md
# stage3_exec_md

Parametrised execute stage for the 7-stage RISC-V pipeline, sitting between the register-read stage and stage 4.
- Resolves operand bypass and computes ALU, jump and branch results.
- Issues the redirect/flush for taken control transfers.
- Adds an iterative multiply/divide unit for the M-subset.
- While a multi-cycle op runs, the block asserts `busy` to hold the upstream stages.
- Datapath width is set by `XLEN`.

## Interface
- `XLEN`, default 32: datapath width; must be ≥ 8.
- `MUL_EN`, default 1: 1 enables ops 8–11; 0 makes them complete as bubbles.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `valid`  in  1  instruction present on the inputs.
- `stall_in`  in  1  downstream stall; freezes all output registers.
- `flush_in`  in  1  kill the current instruction and any multi-cycle op.
- `op`  in  4  0 ADD, 1 SUB, 2 JAL, 3 JALR, 4 BEQ, 5 BNE, 6 BLT (signed), 7 BGE (signed), 8 MUL (low), 9 MULHU, 10 DIVU, 11 REMU; 12–15 behave as ADD.
- `use_imm`  in  1  selects `imm` instead of rs2 as ALU arg2 (ops 0–1 only).
- `bypass`  in  2  bit0 selects rs1 bypass, bit1 selects rs2 bypass.
- `rs1_read`, `rs2_read`, `rs1_bypass_value`, `rs2_bypass_value`, `imm`, `pc`  in  XLEN each  operands and current PC.
- `eval`  out  XLEN  registered result.
- `eval_valid`  out  1  registered; `eval` carries a completed result.
- `s4a_rs2_val`  out  XLEN  registered rs2 value after bypass, for stores.
- `busy`  out  1  combinational; upstream must hold the instruction.
- `do_flush`  out  1  combinational; a taken jump or branch.
- `redirect_addr`  out  XLEN  combinational jump target.

## Operation
- Operand selection:
  - rs1v = `bypass[0]` ? `rs1_bypass_value` : `rs1_read`; rs2v likewise using `bypass[1]`.
  - arg2 = `use_imm` ? `imm` : rs2v.
- "fire" = `valid & ~stall_in & ~flush_in & ~busy`. For ops 8–11, fire instead means completion in DONE (see FSM).
- Single-cycle results, all modulo 2^XLEN:
  - ADD: rs1v+arg2. SUB: rs1v−arg2.
  - JAL and JALR: `eval` = pc+4.
  - Branches: `eval_valid` = 0.
- Control transfers:
  - Branches compare rs1v against rs2v.
  - `do_flush` = `valid & ~stall_in & ~flush_in` & (JAL | JALR | branch taken).
  - `redirect_addr`: pc+imm for JAL and branches; (rs1v+imm) with bit0 cleared for JALR.
- Multiply/divide FSM, states IDLE → RUN → DONE:
  - IDLE + `valid` + op 8–11 + `MUL_EN`: `busy`=1 combinationally. If ~`stall_in` & ~`flush_in`, latch rs1v/rs2v, counter=XLEN−1, and go to RUN.
  - RUN: `busy`=1. One iteration per cycle: radix-2 shift-add for MUL/MULHU (2·XLEN-bit product), restoring division for DIVU/REMU. At counter 0 go to DONE; otherwise decrement.
  - DONE: `busy`=0. The held instruction completes: on an edge with ~`stall_in`, `eval` gets the selected half or quotient/remainder, `eval_valid`=1, and state returns to IDLE. With `stall_in`=1 the block stays in DONE.
  - Divide by zero: DIVU = all-ones, REMU = dividend. This falls out of restoring division and has no special path; latency is unchanged.
- `flush_in`=1 in RUN or DONE: state goes to IDLE at the next edge, no result is written, and `eval_valid`=0.
- On a fire edge, `s4a_rs2_val` gets rs2v. `eval_valid` gets 1 for ADD/SUB/JAL/JALR/completed muldiv, otherwise 0.
- Edge with `stall_in`=1: `eval`, `eval_valid` and `s4a_rs2_val` hold. The FSM keeps iterating in RUN.
- Edge with ~`stall_in` and no fire (bubble, busy, or flush): `eval_valid` gets 0.

## Timing
- Reset: `eval`=0, `eval_valid`=0, `s4a_rs2_val`=0, state IDLE, counter=0. Hence `busy`=0 and `do_flush`=0 (provided `valid`=0).
- Reset asserted mid-RUN: the operation is abandoned and the state is IDLE on the next cycle.
- Single-cycle ops: result appears on `eval` one edge after presentation.
- Muldiv, with no stall or flush:
  - Presented at cycle 0; `busy` is high for cycles 0..XLEN.
  - DONE at cycle XLEN+1; `eval` is updated at the end of cycle XLEN+1.
  - Upstream holds the instruction for XLEN+1 cycles.
- `do_flush` and `redirect_addr` are valid in the same cycle as the instruction. The PC stage registers them.

## Test plan
- Reset low for 2 cycles, then release → all outputs 0, `busy`=0.
- ADD rs1=5, rs2 bypass=7, bypass=2'b10 → next cycle `eval`=12, `eval_valid`=1, `s4a_rs2_val`=7.
- BLT rs1=−1, rs2=1, pc=0x100, imm=0x20 → same-cycle `do_flush`=1, `redirect_addr`=0x120; next cycle `eval_valid`=0. JALR rs1=0x203, imm=0 → target 0x202, `eval`=pc+4.
- MUL 0xFFFF_FFFF×2, then MULHU of the same operands (XLEN=32) → each `busy` for 33 cycles; `eval`=0xFFFF_FFFE, then 0x1.
- DIVU 100/0 then REMU 100/0 → `eval`=0xFFFF_FFFF, then 100; latency identical to 100/7, which gives 14 and 2.
- `flush_in` at RUN iteration 10 → IDLE next cycle, `busy`=0, no `eval_valid` pulse. `stall_in` held 3 cycles in DONE → `eval` is written only after the stall drops.
